// File: rtl/dpdm_decode.sv
// ---------------------------------------------------------------------------
// dpdm_decode
//
// Receive-side DP/DM line decoder. Samples the differential pair once per
// clock, classifies each sample as J, K, SE0, SE1 or idle (undriven), hunts
// for and strips the SYNC pattern (K J K J K J K K), forwards raw payload line
// bits (J=1, K=0) to the NRZI decoder and recognises the end-of-packet
// sequence SE0, SE0, J.
//
// Parameters
//   MAX_BITS   maximum payload symbols per packet; one more data symbol
//              aborts the packet
//   CNT_W      width of bit_count, must be able to hold MAX_BITS
//
// Ports
//   clock      system clock, everything on the rising edge
//   reset      synchronous, active-high reset
//   DP, DM     bus D+ / D- lines
//   out_bit    payload line bit (J=1, K=0), valid when out_valid is high
//   out_valid  out_bit carries a payload symbol this cycle
//   pkt_start  one-cycle pulse, SYNC fully matched
//   pkt_done   one-cycle pulse, valid EOP received
//   rx_error   one-cycle pulse, packet aborted
//   rx_busy    high whenever the receiver is not idle
//   bit_count  payload symbols of the current or most recent packet
//
// Build option
//   DPDM_DECODE_INSYNC_EN  when defined, DP and DM each pass through a
//                          two-flop synchronizer (reset to the J state)
//                          before classification, so sample-to-output
//                          latency grows from 1 to 3 cycles. The packet
//                          state machine is the same in both builds.
// ---------------------------------------------------------------------------
module dpdm_decode #(
  parameter int MAX_BITS = 1024,
  parameter int CNT_W    = 11
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             DP,
  input  logic             DM,
  output logic             out_bit,
  output logic             out_valid,
  output logic             pkt_start,
  output logic             pkt_done,
  output logic             rx_error,
  output logic             rx_busy,
  output logic [CNT_W-1:0] bit_count
);

  typedef enum logic [2:0] {
    SYM_J,
    SYM_K,
    SYM_SE0,
    SYM_SE1,
    SYM_IDLE
  } sym_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SYNC,
    ST_DATA,
    ST_EOP1,
    ST_EOP2
  } state_e;

  // Bit i set means SYNC position i expects a K, clear means a J.
  // Positions 0..7 spell K J K J K J K K.
  localparam logic [7:0]       SYNC_IS_K = 8'b1101_0101;
  localparam logic [2:0]       SYNC_LAST = 3'd7;
  localparam logic [CNT_W-1:0] MAX_CNT   = CNT_W'(MAX_BITS);

  logic lineDp_d;
  logic lineDm_d;

`ifdef DPDM_DECODE_INSYNC_EN
  logic [1:0] dpSync_q;
  logic [1:0] dmSync_q;

  // Two-flop synchronizers for asynchronous bus lines. They reset to the
  // J state so the receiver sees a quiet, idle bus right after reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      dpSync_q <= 2'b11;
      dmSync_q <= 2'b00;
    end else begin
      dpSync_q <= {dpSync_q[0], DP};
      dmSync_q <= {dmSync_q[0], DM};
    end
  end

  assign lineDp_d = dpSync_q[1];
  assign lineDm_d = dmSync_q[1];
`else
  assign lineDp_d = DP;
  assign lineDm_d = DM;
`endif

  // Line state classification. An undriven (X/Z) line is reported as idle;
  // hardware never sees that case, only four-state simulation does.
  sym_e sym_d;

  always_comb begin
    sym_d = SYM_IDLE;
    if (!$isunknown({lineDp_d, lineDm_d})) begin
      case ({lineDp_d, lineDm_d})
        2'b10:   sym_d = SYM_J;
        2'b01:   sym_d = SYM_K;
        2'b00:   sym_d = SYM_SE0;
        default: sym_d = SYM_SE1;
      endcase
    end
  end

  state_e           state_q;
  logic [2:0]       syncIdx_q;
  logic [CNT_W-1:0] bitCount_q;
  logic             outBit_q;
  logic             outValid_q;
  logic             pktStart_q;
  logic             pktDone_q;
  logic             rxError_q;

  sym_e syncWant_d;

  assign syncWant_d = SYNC_IS_K[syncIdx_q] ? SYM_K : SYM_J;

  // Packet state machine. The pulse outputs default low every cycle and are
  // raised only by the transition that produces them, which keeps
  // pkt_start, pkt_done and rx_error mutually exclusive by construction.
  // out_bit keeps its last value between strobes; only out_valid qualifies
  // it. bit_count is cleared only when a new SYNC completes, so it still
  // shows the length of the last packet after done or error.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      syncIdx_q  <= 3'd0;
      bitCount_q <= '0;
      outBit_q   <= 1'b0;
      outValid_q <= 1'b0;
      pktStart_q <= 1'b0;
      pktDone_q  <= 1'b0;
      rxError_q  <= 1'b0;
    end else begin
      outValid_q <= 1'b0;
      pktStart_q <= 1'b0;
      pktDone_q  <= 1'b0;
      rxError_q  <= 1'b0;

      case (state_q)
        ST_IDLE: begin
          // Only a K can open a SYNC; it is pattern position 0, so the hunt
          // continues at position 1.
          if (sym_d == SYM_K) begin
            state_q   <= ST_SYNC;
            syncIdx_q <= 3'd1;
          end
        end

        ST_SYNC: begin
          // A mismatching symbol is consumed; the hunt restarts only on a
          // later K seen from IDLE.
          if (sym_d == syncWant_d) begin
            if (syncIdx_q == SYNC_LAST) begin
              state_q    <= ST_DATA;
              syncIdx_q  <= 3'd0;
              bitCount_q <= '0;
              pktStart_q <= 1'b1;
            end else begin
              syncIdx_q <= syncIdx_q + 3'd1;
            end
          end else begin
            state_q   <= ST_IDLE;
            syncIdx_q <= 3'd0;
            rxError_q <= 1'b1;
          end
        end

        ST_DATA: begin
          case (sym_d)
            SYM_J, SYM_K: begin
              if (bitCount_q == MAX_CNT) begin
                state_q   <= ST_IDLE;
                rxError_q <= 1'b1;
              end else begin
                outValid_q <= 1'b1;
                outBit_q   <= (sym_d == SYM_J);
                bitCount_q <= bitCount_q + CNT_W'(1);
              end
            end
            SYM_SE0: begin
              state_q <= ST_EOP1;
            end
            default: begin
              state_q   <= ST_IDLE;
              rxError_q <= 1'b1;
            end
          endcase
        end

        ST_EOP1: begin
          if (sym_d == SYM_SE0) begin
            state_q <= ST_EOP2;
          end else begin
            state_q   <= ST_IDLE;
            rxError_q <= 1'b1;
          end
        end

        ST_EOP2: begin
          state_q <= ST_IDLE;
          if (sym_d == SYM_J) begin
            pktDone_q <= 1'b1;
          end else begin
            rxError_q <= 1'b1;
          end
        end

        default: begin
          state_q   <= ST_IDLE;
          syncIdx_q <= 3'd0;
        end
      endcase
    end
  end

  assign out_bit   = outBit_q;
  assign out_valid = outValid_q;
  assign pkt_start = pktStart_q;
  assign pkt_done  = pktDone_q;
  assign rx_error  = rxError_q;
  assign bit_count = bitCount_q;
  assign rx_busy   = (state_q != ST_IDLE);

endmodule

// File: tb/tb_dpdm_decode.sv
// ---------------------------------------------------------------------------
// tb_dpdm_decode
//
// Drives directed DP/DM symbol sequences into two receivers sharing the same
// bus: one with the default MAX_BITS and one built with MAX_BITS=8 to reach
// the overflow boundary cheaply. A packet-level reference model tracks the
// symbols of each attempt and predicts every output cycle by cycle; literal
// expectations per scenario (pulse counts, bit counts, bit order, latency)
// pin the model down. Define DPDM_DECODE_INSYNC_EN for both files to exercise
// the synchronizer build with its 3-cycle latency.
// ---------------------------------------------------------------------------
module tb_dpdm_decode;

  localparam logic [1:0] SYM_J   = 2'b10;
  localparam logic [1:0] SYM_K   = 2'b01;
  localparam logic [1:0] SYM_SE0 = 2'b00;
  localparam logic [1:0] SYM_SE1 = 2'b11;

`ifdef DPDM_DECODE_INSYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif

  localparam int HIST_MAX = 128;

  // Symbol strings are sent most significant pair first.
  localparam logic [63:0] SYNC_SEQ = {48'd0, SYM_K, SYM_J, SYM_K, SYM_J,
                                      SYM_K, SYM_J, SYM_K, SYM_K};
  localparam logic [63:0] EOP_SEQ  = {58'd0, SYM_SE0, SYM_SE0, SYM_J};
  localparam logic [15:0] SYNC_PAT = {SYM_K, SYM_J, SYM_K, SYM_J,
                                      SYM_K, SYM_J, SYM_K, SYM_K};

  typedef struct packed {
    logic        valid;
    logic        obit;
    logic        chkBit;
    logic        start;
    logic        done;
    logic        err;
    logic        busy;
    logic [10:0] count;
  } expT;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic DP    = 1'b1;
  logic DM    = 1'b0;

  logic        outBitA, outValidA, pktStartA, pktDoneA, rxErrorA, rxBusyA;
  logic [10:0] bitCountA;
  logic        outBitB, outValidB, pktStartB, pktDoneB, rxErrorB, rxBusyB;
  logic [3:0]  bitCountB;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  bit ready = 1'b0;

  logic [1:0] hist [2][HIST_MAX];
  int         histLen [2];
  int         mCount [2];
  int         maxB [2];
  expT        dline [2][LAT];
  expT        modelE;

  int startSeen [2];
  int doneSeen  [2];
  int errSeen   [2];
  int validSeen [2];
  int snapStart [2];
  int snapDone  [2];
  int snapErr   [2];
  int snapValid [2];
  logic [31:0] bitsA = '0;
  int startCycA = 0;
  int syncSample = 0;

  dpdm_decode dutA (
    .clock     (clock),
    .reset     (reset),
    .DP        (DP),
    .DM        (DM),
    .out_bit   (outBitA),
    .out_valid (outValidA),
    .pkt_start (pktStartA),
    .pkt_done  (pktDoneA),
    .rx_error  (rxErrorA),
    .rx_busy   (rxBusyA),
    .bit_count (bitCountA)
  );

  dpdm_decode #(.MAX_BITS(8), .CNT_W(4)) dutB (
    .clock     (clock),
    .reset     (reset),
    .DP        (DP),
    .DM        (DM),
    .out_bit   (outBitB),
    .out_valid (outValidB),
    .pkt_start (pktStartB),
    .pkt_done  (pktDoneB),
    .rx_error  (rxErrorB),
    .rx_busy   (rxBusyB),
    .bit_count (bitCountB)
  );

  always #5 clock = ~clock;

  // Reference model for one receiver: remembers every symbol of the current
  // attempt (SYNC included) and decides the outcome from the packet rules.
  task automatic modelStep(input int m, input logic [1:0] sym, output expT e);
    int n;
    int run;
    logic [1:0] want;
    e = '0;
    if (histLen[m] >= HIST_MAX) begin
      $display("[TB] FAIL model history: got length %0d, need below %0d", histLen[m], HIST_MAX);
      bad++;
      histLen[m] = 0;
    end
    if (histLen[m] == 0) begin
      if (sym == SYM_K) begin
        hist[m][0] = sym;
        histLen[m] = 1;
      end
    end else begin
      hist[m][histLen[m]] = sym;
      histLen[m]++;
      n = histLen[m];
      if (n <= 8) begin
        want = SYNC_PAT[2*(8-n) +: 2];
        if (sym != want) begin
          e.err = 1'b1;
          histLen[m] = 0;
        end else if (n == 8) begin
          e.start = 1'b1;
          mCount[m] = 0;
        end
      end else begin
        run = 0;
        while (n - 2 - run >= 8 && hist[m][n-2-run] == SYM_SE0) run++;
        if (run == 0) begin
          if (sym == SYM_J || sym == SYM_K) begin
            if (mCount[m] == maxB[m]) begin
              e.err = 1'b1;
              histLen[m] = 0;
            end else begin
              e.valid  = 1'b1;
              e.obit   = (sym == SYM_J);
              e.chkBit = 1'b1;
              mCount[m]++;
            end
          end else if (sym != SYM_SE0) begin
            e.err = 1'b1;
            histLen[m] = 0;
          end
        end else if (run == 1) begin
          if (sym != SYM_SE0) begin
            e.err = 1'b1;
            histLen[m] = 0;
          end
        end else begin
          if (sym == SYM_J) e.done = 1'b1;
          else e.err = 1'b1;
          histLen[m] = 0;
        end
      end
    end
    e.count = 11'(mCount[m]);
    e.busy  = (histLen[m] != 0);
  endtask

  // Model advances on the sampling edge; predictions pass through a delay
  // line matching the build's sample-to-output latency.
  always @(posedge clock) begin
    cyc++;
    if (reset) begin
      ready = 1'b1;
      for (int m = 0; m < 2; m++) begin
        histLen[m] = 0;
        mCount[m]  = 0;
        for (int i = 0; i < LAT; i++) begin
          dline[m][i] = '0;
          dline[m][i].chkBit = 1'b1;
        end
      end
    end else begin
      for (int m = 0; m < 2; m++) begin
        modelStep(m, {DP, DM}, modelE);
        for (int i = 0; i < LAT - 1; i++) dline[m][i] = dline[m][i+1];
        dline[m][LAT-1] = modelE;
      end
    end
  end

  // Compare both receivers against the model on every falling edge.
  always @(negedge clock) begin
    expT act;
    expT ex;
    logic rawBit;
    if (ready) begin
      for (int m = 0; m < 2; m++) begin
        ex = dline[m][0];
        act = '0;
        if (m == 0) begin
          act.valid = outValidA; act.start = pktStartA; act.done = pktDoneA;
          act.err = rxErrorA; act.busy = rxBusyA; act.count = bitCountA;
          rawBit = outBitA;
        end else begin
          act.valid = outValidB; act.start = pktStartB; act.done = pktDoneB;
          act.err = rxErrorB; act.busy = rxBusyB; act.count = 11'(bitCountB);
          rawBit = outBitB;
        end
        act.chkBit = ex.chkBit;
        act.obit   = ex.chkBit ? rawBit : 1'b0;
        total++;
        if (act !== ex) begin
          bad++;
          $display("[TB] FAIL cycle %0d dut%0d outputs: got v=%b b=%b s=%b d=%b e=%b busy=%b cnt=%0d, need v=%b b=%b s=%b d=%b e=%b busy=%b cnt=%0d",
                   cyc, m, act.valid, act.obit, act.start, act.done, act.err, act.busy, act.count,
                   ex.valid, ex.obit, ex.start, ex.done, ex.err, ex.busy, ex.count);
        end
        if (act.start) startSeen[m]++;
        if (act.done)  doneSeen[m]++;
        if (act.err)   errSeen[m]++;
        if (act.valid) validSeen[m]++;
        if (m == 0 && act.valid) bitsA = {bitsA[30:0], rawBit};
        if (m == 0 && act.start) startCycA = cyc;
      end
    end
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    total++;
    if (actual != expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0d, need %0d", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [1:0] sym);
    @(posedge clock);
    #1;
    DP = sym[1];
    DM = sym[0];
  endtask

  task automatic sendSeq(input logic [63:0] seq, input int n);
    for (int i = n - 1; i >= 0; i--) applyStimulus(seq[2*i +: 2]);
  endtask

  // Idle bus long enough for the last symbol to reach the outputs.
  task automatic settle();
    repeat (LAT + 1) applyStimulus(SYM_J);
    @(negedge clock);
    #1;
  endtask

  task automatic snapshot();
    for (int m = 0; m < 2; m++) begin
      snapStart[m] = startSeen[m];
      snapDone[m]  = doneSeen[m];
      snapErr[m]   = errSeen[m];
      snapValid[m] = validSeen[m];
    end
  endtask

  task automatic checkSegment(input string name, input int m, input int expStart,
                              input int expDone, input int expErr, input int expValid,
                              input int expCount);
    int cnt;
    cnt = (m == 0) ? int'(bitCountA) : int'(bitCountB);
    checkOutput($sformatf("%s dut%0d starts", name, m), startSeen[m] - snapStart[m], expStart);
    checkOutput($sformatf("%s dut%0d dones", name, m), doneSeen[m] - snapDone[m], expDone);
    checkOutput($sformatf("%s dut%0d errors", name, m), errSeen[m] - snapErr[m], expErr);
    checkOutput($sformatf("%s dut%0d strobes", name, m), validSeen[m] - snapValid[m], expValid);
    checkOutput($sformatf("%s dut%0d bit_count", name, m), cnt, expCount);
  endtask

  initial begin
    maxB[0] = 1024;
    maxB[1] = 8;
    for (int m = 0; m < 2; m++) begin
      histLen[m] = 0; mCount[m] = 0;
      startSeen[m] = 0; doneSeen[m] = 0; errSeen[m] = 0; validSeen[m] = 0;
    end

    // Reset state
    reset = 1'b1;
    repeat (2) @(posedge clock);
    @(negedge clock);
    #1;
    checkOutput("reset outputs dut0",
                int'({outValidA, outBitA, pktStartA, pktDoneA, rxErrorA, rxBusyA, bitCountA}), 0);
    checkOutput("reset outputs dut1",
                int'({outValidB, outBitB, pktStartB, pktDoneB, rxErrorB, rxBusyB, bitCountB}), 0);
    @(posedge clock);
    #1;
    reset = 1'b0;

    // 1: idle bus, SYNC, payload J K K J, EOP
    $display("[TB] scenario 1: basic packet");
    snapshot();
    repeat (3) applyStimulus(SYM_J);
    sendSeq(SYNC_SEQ, 8);
    syncSample = cyc + 1;
    sendSeq({56'd0, SYM_J, SYM_K, SYM_K, SYM_J}, 4);
    sendSeq(EOP_SEQ, 3);
    settle();
    checkSegment("basic", 0, 1, 1, 0, 4, 4);
    checkSegment("basic", 1, 1, 1, 0, 4, 4);
    checkOutput("basic bit order", int'(bitsA[3:0]), 4'b1001);
    checkOutput("sync-to-start latency", startCycA - syncSample + 1, LAT);

    // 2: broken SYNC (J at position 6), then a good packet K J
    $display("[TB] scenario 2: sync mismatch then recovery");
    snapshot();
    sendSeq({50'd0, SYM_K, SYM_J, SYM_K, SYM_J, SYM_K, SYM_J, SYM_J}, 7);
    applyStimulus(SYM_J);
    sendSeq(SYNC_SEQ, 8);
    sendSeq({60'd0, SYM_K, SYM_J}, 2);
    sendSeq(EOP_SEQ, 3);
    settle();
    checkSegment("badsync", 0, 1, 1, 1, 2, 2);
    checkSegment("badsync", 1, 1, 1, 1, 2, 2);

    // 3: payload J K then SE1
    $display("[TB] scenario 3: SE1 inside payload");
    snapshot();
    sendSeq(SYNC_SEQ, 8);
    sendSeq({58'd0, SYM_J, SYM_K, SYM_SE1}, 3);
    settle();
    checkSegment("se1", 0, 1, 0, 1, 2, 2);
    checkOutput("se1 busy after abort", int'(rxBusyA), 0);

    // 4a: single SE0 followed by J
    $display("[TB] scenario 4: broken EOPs");
    snapshot();
    sendSeq(SYNC_SEQ, 8);
    sendSeq({58'd0, SYM_K, SYM_SE0, SYM_J}, 3);
    settle();
    checkSegment("eop1", 0, 1, 0, 1, 1, 1);

    // 4b: SE0 SE0 followed by K
    snapshot();
    sendSeq(SYNC_SEQ, 8);
    sendSeq({56'd0, SYM_K, SYM_SE0, SYM_SE0, SYM_K}, 4);
    settle();
    checkSegment("eop2", 0, 1, 0, 1, 1, 1);
    checkSegment("eop2", 1, 1, 0, 1, 1, 1);

    // 5: nine J symbols; the MAX_BITS=8 receiver overflows on the ninth
    $display("[TB] scenario 5: payload length limit");
    snapshot();
    sendSeq(SYNC_SEQ, 8);
    repeat (9) applyStimulus(SYM_J);
    sendSeq(EOP_SEQ, 3);
    settle();
    checkSegment("maxbits", 0, 1, 1, 0, 9, 9);
    checkSegment("maxbits", 1, 1, 0, 1, 8, 8);

    // 5b: zero-length payload
    snapshot();
    sendSeq(SYNC_SEQ, 8);
    sendSeq(EOP_SEQ, 3);
    settle();
    checkSegment("empty", 0, 1, 1, 0, 0, 0);
    checkSegment("empty", 1, 1, 1, 0, 0, 0);

    // 6: reset in the middle of a payload, then a clean packet K K J
    $display("[TB] scenario 6: reset during payload");
    snapshot();
    sendSeq(SYNC_SEQ, 8);
    sendSeq({58'd0, SYM_J, SYM_K, SYM_J}, 3);
    @(posedge clock);
    #1;
    reset = 1'b1;
    @(posedge clock);
    @(negedge clock);
    #1;
    checkOutput("midreset outputs dut0",
                int'({outValidA, outBitA, pktStartA, pktDoneA, rxErrorA, rxBusyA, bitCountA}), 0);
    checkOutput("midreset outputs dut1",
                int'({outValidB, outBitB, pktStartB, pktDoneB, rxErrorB, rxBusyB, bitCountB}), 0);
    reset = 1'b0;
    repeat (2) applyStimulus(SYM_J);
    sendSeq(SYNC_SEQ, 8);
    sendSeq({58'd0, SYM_K, SYM_K, SYM_J}, 3);
    sendSeq(EOP_SEQ, 3);
    settle();
    checkSegment("midreset", 0, 2, 1, 0, 6, 3);
    checkSegment("midreset", 1, 2, 1, 0, 6, 3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
